// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
//
// Measures the period of a slow, asynchronous clock (clk_in) in sys_clk cycles,
// compares each measured period against an expected value with a tolerance, and
// tracks lock / fault status.
//
// Ports
//   sys_clk      in   single clock for all logic
//   reset        in   asynchronous, active-low reset
//   clk_in       in   divided clock under test, asynchronous to sys_clk
//   exp_period   in   [WIDTH-1:0] expected clk_in period in sys_clk cycles
//   tol          in   [7:0] allowed absolute deviation from exp_period
//   period       out  [WIDTH-1:0] last measured period
//   period_valid out  one-cycle pulse when period updates
//   edge_pulse   out  one-cycle pulse per detected clk_in rising edge
//   locked       out  LOCK_CNT consecutive in-range periods seen
//   fault        out  sticky out-of-range / timeout indication
//   state_dbg    out  [1:0] current FSM state (0 IDLE, 1 MEASURE, 2 LOCKED,
//                     3 FAULT) for observation only
//
// period_valid is a pure strobe with no back-pressure: period holds its value
// until the next pulse, and a consumer that misses the pulse can still read
// period afterwards.
// -----------------------------------------------------------------------------
module clk_monitor #(
  parameter int WIDTH    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic [WIDTH-1:0] exp_period,
  input  logic [7:0]       tol,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             edge_pulse,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       state_dbg
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  // Comparison width wide enough for both the WIDTH+1 difference and tol.
  localparam int CW = (WIDTH + 1 > 8) ? WIDTH + 1 : 8;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detector
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic prev;

  // edge_pulse is registered, so it appears on the third sys_clk edge after
  // clk_in rises: sync1, sync2, then the edge flop itself.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      prev       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= clk_in;
      sync2      <= sync1;
      prev       <= sync2;
      edge_pulse <= sync2 & ~prev;
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter: restarts at 1 on each edge so that at the next edge it
  // holds exactly the number of sys_clk cycles between the two edges.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] cnt;
  logic             cnt_sat;

  assign cnt_sat = (cnt == CNT_MAX);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (edge_pulse) begin
      cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (!cnt_sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Range check on the period being captured this cycle. The difference is
  // taken one bit wider and signed so that a period far below exp_period
  // cannot wrap into a small positive value.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH:0] diff;
  logic        [WIDTH:0] abs_diff;
  logic                  in_range;

  always_comb begin
    diff     = $signed({1'b0, cnt}) - $signed({1'b0, exp_period});
    abs_diff = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    in_range = (CW'(abs_diff) <= CW'(tol));
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t          state;
  state_t          state_n;
  logic [GW-1:0]   good_cnt;
  logic [GW-1:0]   good_n;
  logic [GW-1:0]   good_inc;
  logic            fault_flag;
  logic            fault_flag_n;
  logic            period_load;

  // good_cnt saturates at LOCK_CNT so it stays meaningful while LOCKED.
  assign good_inc = (good_cnt == GW'(LOCK_CNT)) ? good_cnt : good_cnt + 1'b1;

  always_comb begin
    state_n      = state;
    good_n       = good_cnt;
    fault_flag_n = fault_flag;
    period_load  = 1'b0;

    case (state)
      S_IDLE: begin
        // First edge only starts a measurement; there is no prior edge to
        // measure from, so no period is produced.
        if (edge_pulse) begin
          state_n = S_MEASURE;
          good_n  = '0;
        end
      end

      S_MEASURE: begin
        if (edge_pulse) begin
          period_load = 1'b1;
          if (in_range) begin
            good_n = good_inc;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_n = S_LOCKED;
            end
          end else begin
            good_n = '0;
          end
        end else if (cnt_sat) begin
          // Timeout before ever locking: not treated as a fault.
          state_n = S_IDLE;
          good_n  = '0;
        end
      end

      S_LOCKED: begin
        if (edge_pulse) begin
          period_load = 1'b1;
          if (in_range) begin
            good_n = good_inc;
          end else begin
            state_n      = S_FAULT;
            good_n       = '0;
            fault_flag_n = 1'b1;
          end
        end else if (cnt_sat) begin
          state_n      = S_IDLE;
          good_n       = '0;
          fault_flag_n = 1'b1;
        end
      end

      S_FAULT: begin
        if (edge_pulse) begin
          period_load = 1'b1;
          if (in_range) begin
            good_n = good_inc;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_n      = S_LOCKED;
              fault_flag_n = 1'b0;
            end
          end else begin
            good_n = '0;
          end
        end else if (cnt_sat) begin
          state_n      = S_IDLE;
          good_n       = '0;
          fault_flag_n = 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        good_n  = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      good_cnt   <= '0;
      fault_flag <= 1'b0;
    end else begin
      state      <= state_n;
      good_cnt   <= good_n;
      fault_flag <= fault_flag_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. locked and fault are derived from the registered state / flag and
  // registered once more, so they change one cycle after the state does.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      if (period_load) begin
        period <= cnt;
      end
      period_valid <= period_load;
      locked       <= (state == S_LOCKED);
      fault        <= fault_flag;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_monitor
//
// Two instances: dut_a (WIDTH=16) for lock / fault / tolerance / reset
// behaviour, dut_b (WIDTH=8) for the counter-saturation timeout. Expected
// periods are pushed when a clk_in rise is driven and popped when the DUT
// pulses period_valid.
// -----------------------------------------------------------------------------
module tb_clk_monitor;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        reset_a, clk_in_a;
  logic [15:0] exp_a;
  logic [7:0]  tol_a;
  logic [15:0] period_a;
  logic        pv_a, ep_a, locked_a, fault_a;
  logic [1:0]  st_a;

  logic        reset_b, clk_in_b;
  logic [7:0]  exp_b;
  logic [7:0]  tol_b;
  logic [7:0]  period_b;
  logic        pv_b, ep_b, locked_b, fault_b;
  logic [1:0]  st_b;

  clk_monitor #(.WIDTH(16), .LOCK_CNT(4)) dut_a (
    .sys_clk(sys_clk), .reset(reset_a), .clk_in(clk_in_a),
    .exp_period(exp_a), .tol(tol_a), .period(period_a),
    .period_valid(pv_a), .edge_pulse(ep_a), .locked(locked_a),
    .fault(fault_a), .state_dbg(st_a)
  );

  clk_monitor #(.WIDTH(8), .LOCK_CNT(4)) dut_b (
    .sys_clk(sys_clk), .reset(reset_b), .clk_in(clk_in_b),
    .exp_period(exp_b), .tol(tol_b), .period(period_b),
    .period_valid(pv_b), .edge_pulse(ep_b), .locked(locked_b),
    .fault(fault_b), .state_dbg(st_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [15:0] exp_qa[$];
  logic [7:0]  exp_qb[$];

  int cyc = 0;
  int rise_cyc_a = -100, rise_cyc_b = -100;
  int rises_a = 0, rises_b = 0;
  int edges_a = 0, edges_b = 0;
  bit have_prev_a = 0, have_prev_b = 0;
  int last_len_a = 0, last_len_b = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: samples 1 time unit after each active edge.
  always @(posedge sys_clk) begin
    cyc++;
    #1;
    if (pv_a) begin
      if (exp_qa.size() == 0) check("a_unexpected_period_valid", 1, 0);
      else                    check("a_period", period_a, exp_qa.pop_front());
    end
    if (pv_b) begin
      if (exp_qb.size() == 0) check("b_unexpected_period_valid", 1, 0);
      else                    check("b_period", period_b, exp_qb.pop_front());
    end
    if (ep_a) begin
      edges_a++;
      check("a_edge_latency", cyc - rise_cyc_a, 3);
    end
    if (ep_b) begin
      edges_b++;
      check("b_edge_latency", cyc - rise_cyc_b, 3);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clk_in period of len sys_clk cycles, rising on a sys_clk negedge, so
  // consecutive rises are exactly len cycles apart.
  task automatic clk_cycle(input int d, input int len);
    @(negedge sys_clk);
    if (d == 0) begin
      clk_in_a   = 1'b1;
      rise_cyc_a = cyc;
      rises_a++;
      if (have_prev_a) exp_qa.push_back(16'(last_len_a));
      have_prev_a = 1'b1;
      last_len_a  = len;
    end else begin
      clk_in_b   = 1'b1;
      rise_cyc_b = cyc;
      rises_b++;
      if (have_prev_b) exp_qb.push_back(8'(last_len_b));
      have_prev_b = 1'b1;
      last_len_b  = len;
    end
    repeat (len / 2) @(negedge sys_clk);
    if (d == 0) clk_in_a = 1'b0;
    else        clk_in_b = 1'b0;
    repeat (len - len / 2 - 1) @(negedge sys_clk);
  endtask

  task automatic reset_dut_a();
    @(negedge sys_clk);
    reset_a = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset_a     = 1'b1;
    have_prev_a = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for dut_a: one clk_in period per row, locked/fault checked at
  // the end of the row.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit rst;
    int len;
    int tol;
    bit exp_locked;
    bit exp_fault;
  } vec_t;

  vec_t vecs[21];

  initial begin
    reset_a = 1'b0; clk_in_a = 1'b0; exp_a = 16'd30; tol_a = 8'd1;
    reset_b = 1'b0; clk_in_b = 1'b0; exp_b = 8'd30;  tol_b = 8'd1;

    // lock at 30, then a 33 stretch, relock, then 29/31 jitter with tol=1
    vecs[0]  = '{1'b0, 30, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 30, 1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 30, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 30, 1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 30, 1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 33, 1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 30, 1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 30, 1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 30, 1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 30, 1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 29, 1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 31, 1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 29, 1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 31, 1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 30, 1, 1'b1, 1'b0};
    // after reset, 29/31 jitter with tol=0 never locks and never faults
    vecs[15] = '{1'b1, 29, 0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 31, 0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 29, 0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 31, 0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 29, 0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 31, 0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_a_period", period_a, 0);
    check("rst_a_valid", pv_a, 0);
    check("rst_a_edge", ep_a, 0);
    check("rst_a_locked", locked_a, 0);
    check("rst_a_fault", fault_a, 0);
    check("rst_a_state", st_a, 0);
    check("rst_b_period", period_b, 0);
    check("rst_b_locked", locked_b, 0);
    check("rst_b_fault", fault_b, 0);
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Table-driven part on dut_a
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].rst) begin
        reset_dut_a();
        check("a_after_reset_fault", fault_a, 0);
      end
      tol_a = 8'(vecs[i].tol);
      clk_cycle(0, vecs[i].len);
      check($sformatf("a_vec%0d_locked", i), locked_a, vecs[i].exp_locked);
      check($sformatf("a_vec%0d_fault", i), fault_a, vecs[i].exp_fault);
    end

    // Relock, then reset in the middle of a period (cnt = 17)
    tol_a = 8'd1;
    for (int i = 0; i < 5; i++) clk_cycle(0, 30);
    check("a_relock_locked", locked_a, 1);
    @(negedge sys_clk);
    clk_in_a   = 1'b1;
    rise_cyc_a = cyc;
    rises_a++;
    exp_qa.push_back(16'(last_len_a));
    repeat (15) @(negedge sys_clk);
    clk_in_a = 1'b0;
    repeat (5) @(negedge sys_clk);
    reset_a = 1'b0;
    #1;
    check("a_midrst_period", period_a, 0);
    check("a_midrst_valid", pv_a, 0);
    check("a_midrst_edge", ep_a, 0);
    check("a_midrst_locked", locked_a, 0);
    check("a_midrst_fault", fault_a, 0);
    check("a_midrst_state", st_a, 0);
    repeat (2) @(negedge sys_clk);
    reset_a     = 1'b1;
    have_prev_a = 1'b0;
    repeat (10) @(negedge sys_clk);
    // First edge after release is an IDLE edge: no period_valid expected.
    clk_cycle(0, 30);
    check("a_postrst_state", st_a, 1);
    clk_cycle(0, 30);
    check("a_postrst_locked", locked_a, 0);

    // dut_b: lock, stop clk_in, saturate, restart
    for (int i = 0; i < 5; i++) clk_cycle(1, 30);
    check("b_locked", locked_b, 1);
    check("b_fault_pre", fault_b, 0);
    repeat (200) @(negedge sys_clk);
    check("b_still_locked", locked_b, 1);
    repeat (100) @(negedge sys_clk);
    check("b_timeout_state", st_b, 0);
    check("b_timeout_fault", fault_b, 1);
    check("b_timeout_locked", locked_b, 0);
    check("b_timeout_period", period_b, 30);
    have_prev_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clk_cycle(1, 30);
      check($sformatf("b_restart%0d_locked", i), locked_b, (i == 4) ? 1 : 0);
    end

    // Completion checks
    repeat (10) @(negedge sys_clk);
    check("a_queue_drained", exp_qa.size(), 0);
    check("b_queue_drained", exp_qb.size(), 0);
    check("a_edge_count", edges_a, rises_a);
    check("b_edge_count", edges_b, rises_b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of period counter, period, and exp_period.
REQ-002 SHALL have parameter LOCK_CNT, default 4: consecutive in-range periods required to assert locked.
REQ-003 SHALL have port sys_clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clk_in, input, 1: divided clock under test, asynchronous to sys_clk.
REQ-006 SHALL have port exp_period, input, WIDTH: expected clk_in period in sys_clk cycles.
REQ-007 SHALL have port tol, input, 8: allowed absolute deviation from exp_period, in cycles.
REQ-008 SHALL have port period, output, WIDTH: last measured period in sys_clk cycles.
REQ-009 SHALL have port period_valid, output, 1: one-cycle pulse when period updates.
REQ-010 SHALL have port edge_pulse, output, 1: one-cycle pulse per detected clk_in rising edge.
REQ-011 SHALL have port locked, output, 1: clk_in within tolerance for LOCK_CNT consecutive periods.
REQ-012 SHALL have port fault, output, 1: sticky out-of-range or timeout indication.

Function
REQ-013 SHALL pass clk_in through a 2-flop synchroniser, followed by a third flop holding the previous sample.
REQ-014 SHALL assert edge_pulse for exactly one cycle when sync2=1 and prev=0, at the 3rd sys_clk rising edge after clk_in rises (clk_in setup met).
REQ-015 SHALL hold counter cnt (WIDTH bits): load 1 on edge_pulse, else increment, saturating at 2^WIDTH-1.
REQ-016 SHALL, on edge_pulse in MEASURE, LOCKED or FAULT, register period <= cnt and pulse period_valid the same cycle as the load.
REQ-017 SHALL compute in-range as |period - exp_period| <= tol, using WIDTH+1-bit signed arithmetic (no wrap-around); exp_period and tol are sampled in the edge cycle.
REQ-018 SHALL implement states IDLE, MEASURE, LOCKED, FAULT; good_cnt counts consecutive in-range periods, saturating at LOCK_CNT.
REQ-019 IDLE: the first edge_pulse goes to MEASURE; no period_valid is produced and good_cnt is cleared.
REQ-020 MEASURE: an in-range period increments good_cnt; when good_cnt reaches LOCK_CNT, go to LOCKED; an out-of-range period clears good_cnt and stays in MEASURE.
REQ-021 LOCKED: locked=1; an out-of-range period goes to FAULT, sets locked=0 and fault=1, and clears good_cnt.
REQ-022 FAULT: in-range periods increment good_cnt; at LOCK_CNT go to LOCKED and clear fault; out-of-range periods clear good_cnt.
REQ-023 SHALL, when cnt reaches saturation in MEASURE, LOCKED or FAULT, go to IDLE, set locked=0, and set fault=1 only if leaving LOCKED or FAULT; period is not updated.
REQ-024 SHALL let edge_pulse take priority over saturation in the same cycle: the edge is processed normally.
REQ-025 SHALL update locked and fault in the cycle after the state change, registered, so they are never combinational.

Reset
REQ-026 SHALL, while reset=0, force: synchroniser flops 0, cnt=0, good_cnt=0, state IDLE, period=0, period_valid=0, edge_pulse=0, locked=0, fault=0.
REQ-027 SHALL, on reset assertion mid-measurement, discard the partial period; after release, the first edge is treated as an IDLE edge.

Verification
REQ-028 clk_in period 30 cycles, exp_period=30, tol=1 -> period_valid pulses carry period=30; locked=1 after the 5th rising edge; fault=0.
REQ-029 While locked, stretch one clk_in period to 33 -> period=33, fault=1, locked=0; after 4 further periods of 30, locked=1 and fault=0.
REQ-030 Period alternating 29/31, tol=1 -> stays locked; with tol=0, lock is never reached and fault stays 0 if lock never occurred.
REQ-031 WIDTH=8, clk_in stopped while locked -> saturation at cnt=255 gives IDLE, fault=1, locked=0; a restarted clk_in relocks after LOCK_CNT+1 edges.
REQ-032 Reset pulse at cnt=17 mid-period -> all outputs 0 immediately; the next edge produces no period_valid.
